xeng_vacc: RTL and testbench

Long-term vector accumulator downstream of the X-engine baseline tap chain. Takes the serially-accumulated 4-Stokes complex correlation words leaving the last tap (`acc_out`/`valid_out`) and sums them over `acc_len` consecutive output vectors in a single-port-per-side BRAM. Emits each completed integration once as a widened vector for packetisation.

---
 rtl/xeng_vacc.sv | 118 +++++++++++
 tb/tb_xeng_vacc.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/xeng_vacc.sv
// xeng_vacc: long-term BRAM vector accumulator (saturating when XENG_VACC_SATURATE_EN is defined)
module xeng_vacc #(
  parameter int IN_BITS      = 16,
  parameter int OUT_BITS     = 32,
  parameter int VECTOR_LEN   = 36,
  parameter int ACC_LEN_BITS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sync,
  input  logic [ACC_LEN_BITS-1:0] acc_len,
  input  logic [8*IN_BITS-1:0]    din,
  input  logic                    din_valid,
  output logic [8*OUT_BITS-1:0]   dout,
  output logic                    dout_valid,
  output logic                    dout_last,
  output logic                    ovf
);
  localparam int AW = $clog2(VECTOR_LEN);
`ifdef XENG_VACC_SATURATE_EN
  localparam int EW = OUT_BITS + 1;
`else
  localparam int EW = OUT_BITS;
`endif
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [AW-1:0] addr, cur_addr, s1_addr, s2_addr, s3_addr;
  logic [ACC_LEN_BITS-1:0] vec, cur_vec, acc_len_q, cur_len;
  logic acc, addr_wrap, vec_wrap, wr;
  logic [8*IN_BITS-1:0] s1_din, s2_din;
  logic s1_valid, s1_first, s1_dump, s1_last;
  logic s2_valid, s2_first, s2_dump, s2_last;
  logic s3_valid, s3_dump, s3_last, s3_clamp;
  logic [8*OUT_BITS-1:0] mem [VECTOR_LEN];
  logic [8*OUT_BITS-1:0] rd, sum, s3_sum;
  logic signed [EW-1:0] ext;
  logic clamp;
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // a sync cycle behaves as if the counters were already cleared and acc_len already latched
  always_comb begin
    state_nx  = sync ? RUN : state;
    acc       = din_valid & (sync | state == RUN);
    cur_addr  = sync ? '0 : addr;
    cur_vec   = sync ? '0 : vec;
    cur_len   = sync ? (acc_len == '0 ? ACC_LEN_BITS'(1) : acc_len) : acc_len_q;
    addr_wrap = cur_addr == AW'(VECTOR_LEN - 1);
    vec_wrap  = cur_vec == cur_len - 1'b1;
    wr        = s3_valid & ~sync & ~rst;
  end
  always_ff @(posedge clk)
    if (rst) begin
      addr      <= '0;
      vec       <= '0;
      acc_len_q <= ACC_LEN_BITS'(1);
    end else begin
      if (sync) acc_len_q <= cur_len;
      if (acc) begin
        addr <= addr_wrap ? '0 : cur_addr + 1'b1;
        vec  <= addr_wrap ? (vec_wrap ? '0 : cur_vec + 1'b1) : cur_vec;
      end else if (sync) begin
        addr <= '0;
        vec  <= '0;
      end
    end
  always_ff @(posedge clk) begin
    s1_valid <= ~rst & acc;
    s2_valid <= ~rst & ~sync & s1_valid;
    s3_valid <= ~rst & ~sync & s2_valid;
    s1_din   <= din;
    s1_addr  <= cur_addr;
    s1_first <= cur_vec == '0;
    s1_dump  <= vec_wrap;
    s1_last  <= addr_wrap;
    s2_din   <= s1_din;
    s2_addr  <= s1_addr;
    s2_first <= s1_first;
    s2_dump  <= s1_dump;
    s2_last  <= s1_last;
    s3_sum   <= sum;
    s3_clamp <= clamp;
    s3_addr  <= s2_addr;
    s3_dump  <= s2_dump;
    s3_last  <= s2_last;
  end
  // write at k+3 always precedes the next read of that address (>= k+5)
  always_ff @(posedge clk) begin
    if (wr) mem[s3_addr] <= s3_sum;
    rd <= mem[s1_addr];
  end
  always_comb begin
    sum   = '0;
    clamp = 1'b0;
    ext   = '0;
    for (int c = 0; c < 8; c++) begin
      ext = (s2_first ? '0 : EW'($signed(rd[c*OUT_BITS +: OUT_BITS])))
          + EW'($signed(s2_din[c*IN_BITS +: IN_BITS]));
`ifdef XENG_VACC_SATURATE_EN
      clamp = clamp | (ext[OUT_BITS] ^ ext[OUT_BITS-1]);
      sum[c*OUT_BITS +: OUT_BITS] = (ext[OUT_BITS] ^ ext[OUT_BITS-1])
          ? {ext[OUT_BITS], {(OUT_BITS-1){~ext[OUT_BITS]}}} : ext[OUT_BITS-1:0];
`else
      sum[c*OUT_BITS +: OUT_BITS] = ext;
`endif
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      dout_valid <= wr & s3_dump;
      dout_last  <= wr & s3_dump & s3_last;
      if (wr & s3_dump) dout <= s3_sum;
      ovf <= ~sync & (ovf | (s3_valid & s3_clamp));
    end
endmodule

// File: tb/tb_xeng_vacc.sv
// tb_xeng_vacc: directed self-checking bench; a second instance at OUT_BITS=17 covers overflow.
module tb_xeng_vacc;
  logic clk = 1'b0, rst = 1'b1, sync = 1'b0, din_valid = 1'b0;
  logic [15:0] acc_len = 16'd1;
  logic [127:0] din = '0;
  logic [255:0] dout;
  logic dout_valid, dout_last, ovf;
  logic [135:0] dout2;
  logic dout_valid2, dout_last2, ovf2;
  int cyc = 0;
  int n_chk = 0, n_fail = 0;
  logic [255:0] q_d[$];
  logic q_l[$];
  int q_t[$];
  logic [135:0] q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  xeng_vacc dut (.clk(clk), .rst(rst), .sync(sync), .acc_len(acc_len), .din(din),
    .din_valid(din_valid), .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last), .ovf(ovf));
  xeng_vacc #(.OUT_BITS(17)) dut2 (.clk(clk), .rst(rst), .sync(sync), .acc_len(acc_len), .din(din),
    .din_valid(din_valid), .dout(dout2), .dout_valid(dout_valid2), .dout_last(dout_last2), .ovf(ovf2));

  always @(negedge clk) begin
    if (dout_valid) begin
      q_d.push_back(dout);
      q_l.push_back(dout_last);
      q_t.push_back(cyc);
    end
    if (dout_valid2) q2.push_back(dout2);
  end

  task check(input string tag, input logic [255:0] got, input logic [255:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [127:0] pin(input int v);
    logic [127:0] r;
    for (int c = 0; c < 8; c++) r[c*16 +: 16] = v[15:0];
    return r;
  endfunction

  function automatic logic [255:0] pout(input int v);
    logic [255:0] r;
    for (int c = 0; c < 8; c++) r[c*32 +: 32] = v;
    return r;
  endfunction

  function automatic logic [135:0] p17(input logic [16:0] v);
    logic [135:0] r;
    for (int c = 0; c < 8; c++) r[c*17 +: 17] = v;
    return r;
  endfunction

  task drive(input logic v, input logic s, input logic [127:0] d);
    @(negedge clk);
    din_valid = v;
    sync = s;
    din = d;
  endtask

  task idle(input int n);
    repeat (n) drive(1'b0, 1'b0, '0);
  endtask

  task clr;
    q_d.delete();
    q_l.delete();
    q_t.delete();
    q2.delete();
  endtask

  initial begin
    int t0, nl;
    logic [16:0] e17;
    logic eovf;
    repeat (3) @(negedge clk);
    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_last", dout_last, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    // idle: no sync, valid input ignored
    repeat (50) drive(1'b1, 1'b0, pin(7));
    idle(6);
    check("idle_nodump", q_d.size(), 0);
    // basic dump
    clr();
    acc_len = 16'd4;
    drive(1'b0, 1'b1, '0);
    t0 = 0;
    for (int i = 0; i < 144; i++) begin
      drive(1'b1, 1'b0, pin(3));
      if (i == 108) t0 = cyc + 1;
    end
    idle(6);
    check("basic_count", q_d.size(), 36);
    nl = 0;
    for (int j = 0; j < q_d.size(); j++) begin
      check("basic_val", q_d[j], pout(12));
      nl += int'(q_l[j]);
    end
    check("basic_lat", q_t[0] - t0, 3);
    check("basic_nlast", nl, 1);
    check("basic_last35", q_l[35], 1);
    // gapped, back-to-back integrations
    clr();
    acc_len = 16'd2;
    drive(1'b0, 1'b1, '0);
    for (int i = 0; i < 216; i++) begin
      idle($urandom_range(0, 2));
      drive(1'b1, 1'b0, pin(i % 36));
    end
    idle(6);
    check("gap_count", q_d.size(), 108);
    for (int j = 0; j < q_d.size(); j++) begin
      check("gap_val", q_d[j], pout(2 * (j % 36)));
      check("gap_last", q_l[j], (j % 36) == 35);
    end
    // acc_len 0 and 1 dump every vector directly
    for (int len = 0; len < 2; len++) begin
      clr();
      acc_len = 16'(len);
      drive(1'b0, 1'b1, '0);
      for (int i = 0; i < 36; i++) begin
        drive(1'b1, 1'b0, pin(-5));
        if (i == 0) t0 = cyc + 1;
      end
      idle(6);
      check("len01_count", q_d.size(), 36);
      check("len01_first", q_d[0], pout(-5));
      check("len01_lastw", q_d[35], 256'h0 | {8{32'hFFFFFFFB}});
      check("len01_lat", q_t[0] - t0, 3);
    end
    // mid-integration sync at vec=1, addr=10
    clr();
    acc_len = 16'd3;
    drive(1'b0, 1'b1, '0);
    repeat (46) drive(1'b1, 1'b0, pin(100));
    drive(1'b1, 1'b1, pin(1));
    for (int i = 0; i < 107; i++) begin
      drive(1'b1, 1'b0, pin(1));
      if (i == 106) t0 = cyc + 1;
    end
    idle(6);
    check("mid_count", q_d.size(), 36);
    check("mid_first", q_d[0], pout(3));
    check("mid_lastw", q_d[35], pout(3));
    check("mid_last35", q_l[35], 1);
    check("mid_time", q_t[35] - t0, 3);
    // in-flight dump words are flushed by sync
    clr();
    acc_len = 16'd1;
    drive(1'b0, 1'b1, '0);
    repeat (20) drive(1'b1, 1'b0, pin(9));
    drive(1'b1, 1'b1, pin(4));
    repeat (35) drive(1'b1, 1'b0, pin(4));
    idle(6);
    check("flush_count", q_d.size(), 53);
    check("flush_old", q_d[16], pout(9));
    check("flush_new", q_d[17], pout(4));
    check("flush_last", q_l[52], 1);
    // overflow on the 17-bit instance
`ifdef XENG_VACC_SATURATE_EN
    e17 = 17'h0FFFF;
    eovf = 1'b1;
`else
    e17 = 17'h1FFFC;
    eovf = 1'b0;
`endif
    clr();
    acc_len = 16'd4;
    drive(1'b0, 1'b1, '0);
    repeat (144) drive(1'b1, 1'b0, pin(32'h7FFF));
    idle(6);
    check("ovf_count", q2.size(), 36);
    check("ovf_first", q2[0], p17(e17));
    check("ovf_lastw", q2[35], p17(e17));
    check("ovf_flag", ovf2, eovf);
    check("ovf_wide", q_d[0], pout(131068));
    check("ovf_wide_flag", ovf, 0);
    drive(1'b0, 1'b1, '0);
    idle(1);
    check("ovf_clear", ovf2, 0);
    // rst mid-operation drops in-flight words
    acc_len = 16'd1;
    drive(1'b0, 1'b1, '0);
    repeat (10) drive(1'b1, 1'b0, pin(2));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    clr();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) drive(1'b1, 1'b0, pin(2));
    idle(6);
    check("rst_mid", q_d.size(), 0);
    // rst and sync together: rst wins, stays idle
    @(negedge clk);
    rst = 1'b1;
    sync = 1'b1;
    din_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sync = 1'b0;
    repeat (40) drive(1'b1, 1'b0, pin(2));
    idle(6);
    check("rst_sync", q_d.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
